grostl_control_serial_m: RTL and testbench

- Sequencer that drives the masked serial Grostl-512 compression datapath: write enables, mux selects, round and column counters.
- Runs one compression f(h,m) = P(h^m) ^ Q(m) ^ h per start request.
- Sits between the host interface (message, IV and mask supply) and the datapath.
- Datapath processes one column per two cycles: phase A fills the pipeline register, phase B writes the rotated column back to the message register.

---
 rtl/grostl_ctrl_pkg.sv | 30 +++
 rtl/grostl_round_counter.sv | 63 ++++++
 rtl/grostl_control_serial_m.sv | 132 +++++++++++++
 tb/tb_grostl_control_serial_m.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/grostl_ctrl_pkg.sv
// ============================================================================
// grostl_ctrl_pkg : shared types and constants for the serial Grostl sequencer
// Revision: 1.0
// ============================================================================
`default_nettype none

package grostl_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_IDLE  = 4'd0,
        ST_LOAD1 = 4'd1,
        ST_XOR   = 4'd2,
        ST_PRND  = 4'd3,
        ST_FOLDP = 4'd4,
        ST_LOAD2 = 4'd5,
        ST_QRND  = 4'd6,
        ST_FOLDQ = 4'd7,
        ST_DONE  = 4'd8
    } state_e;

    localparam logic [1:0] SEL_M_IN  = 2'd0;
    localparam logic [1:0] SEL_M_RND = 2'd1;
    localparam logic [1:0] SEL_M_XOR = 2'd2;

    localparam int COLS        = 8;
    localparam int CYC_PER_RND = 16;

endpackage

`default_nettype wire

// File: rtl/grostl_round_counter.sv
// ============================================================================
// grostl_round_counter : cycle-in-round (k) and round counters for one permutation
// Revision: 1.0
// ============================================================================
`default_nettype none

module grostl_round_counter
    import grostl_ctrl_pkg::*;
#(
    parameter int ROUNDS = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr_i,
    input  logic       en_i,
    output logic [3:0] rnd_o,
    output logic [2:0] col_o,
    output logic       phase_o,
    output logic       sel_d_o,
    output logic       last_o
);

    logic [3:0] k_q, k_d;
    logic [3:0] rnd_q, rnd_d;
    logic       k_end;

    assign k_end  = (k_q == 4'(CYC_PER_RND - 1));
    assign last_o = k_end && (rnd_q == 4'(ROUNDS - 1));

    // The final increment wraps both counters to zero, so the FSM leaves a
    // permutation with rnd/col already cleared.
    always_comb begin
        k_d   = k_q;
        rnd_d = rnd_q;
        if (clr_i) begin
            k_d   = 4'd0;
            rnd_d = 4'd0;
        end else if (en_i) begin
            k_d = k_q + 4'd1;
            if (k_end) begin
                rnd_d = last_o ? 4'd0 : rnd_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            k_q   <= 4'd0;
            rnd_q <= 4'd0;
        end else begin
            k_q   <= k_d;
            rnd_q <= rnd_d;
        end
    end

    assign rnd_o   = rnd_q;
    assign col_o   = k_q[3:1];
    assign phase_o = k_q[0];
    assign sel_d_o = (k_q == 4'd0);

endmodule

`default_nettype wire

// File: rtl/grostl_control_serial_m.sv
// ============================================================================
// grostl_control_serial_m : Moore sequencer for the masked serial Grostl-512 f(h,m)
// Revision: 1.0
// ============================================================================
`default_nettype none

module grostl_control_serial_m
    import grostl_ctrl_pkg::*;
#(
    parameter int ROUNDS = 10
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start_i,
    input  logic                     first_i,
    output logic                     busy_o,
    output logic                     done_o,
    output logic                     m_load_o,
    output logic                     wr_m_o,
    output logic                     wr_h_o,
    output logic [1:0]               sel_m_o,
    output logic                     sel_h_o,
    output logic                     sel_d_o,
    output logic                     sel_pq_o,
    output logic [3:0]               rnd_o,
    output logic [$clog2(COLS)-1:0]  col_o
);

    state_e state_q, state_d;
    logic   first_q, first_d;
    logic   in_rnd;
    logic   cnt_phase, cnt_sel_d, cnt_last;

    assign in_rnd = (state_q == ST_PRND) || (state_q == ST_QRND);

    grostl_round_counter #(
        .ROUNDS (ROUNDS)
    ) u_round_counter (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (state_q == ST_IDLE),
        .en_i    (in_rnd),
        .rnd_o   (rnd_o),
        .col_o   (col_o),
        .phase_o (cnt_phase),
        .sel_d_o (cnt_sel_d),
        .last_o  (cnt_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            first_q <= 1'b0;
        end else begin
            state_q <= state_d;
            first_q <= first_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        first_d  = first_q;
        busy_o   = 1'b1;
        done_o   = 1'b0;
        m_load_o = 1'b0;
        wr_m_o   = 1'b0;
        wr_h_o   = 1'b0;
        sel_m_o  = SEL_M_IN;
        sel_h_o  = 1'b0;
        sel_d_o  = 1'b0;
        sel_pq_o = 1'b0;
        case (state_q)
            ST_IDLE: begin
                busy_o = 1'b0;
                if (start_i) begin
                    state_d = ST_LOAD1;
                    first_d = first_i;
                end
            end
            ST_LOAD1: begin
                wr_m_o   = 1'b1;
                m_load_o = 1'b1;
                wr_h_o   = first_q;
                state_d  = ST_XOR;
            end
            ST_XOR: begin
                wr_m_o  = 1'b1;
                sel_m_o = SEL_M_XOR;
                state_d = ST_PRND;
            end
            ST_PRND, ST_QRND: begin
                // Phase B writes the rotated column back; the P/Q select stays
                // steady across both phases since the mask path is combinational.
                sel_m_o  = SEL_M_RND;
                wr_m_o   = cnt_phase;
                sel_d_o  = cnt_sel_d;
                sel_pq_o = (state_q == ST_QRND);
                if (cnt_last) begin
                    state_d = (state_q == ST_PRND) ? ST_FOLDP : ST_FOLDQ;
                end
            end
            ST_FOLDP: begin
                wr_h_o  = 1'b1;
                sel_h_o = 1'b1;
                state_d = ST_LOAD2;
            end
            ST_LOAD2: begin
                wr_m_o   = 1'b1;
                m_load_o = 1'b1;
                state_d  = ST_QRND;
            end
            ST_FOLDQ: begin
                wr_m_o  = 1'b1;
                sel_m_o = SEL_M_XOR;
                wr_h_o  = 1'b1;
                sel_h_o = 1'b1;
                state_d = ST_DONE;
            end
            ST_DONE: begin
                done_o  = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                busy_o  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_grostl_control_serial_m.sv
// ============================================================================
// tb_grostl_control_serial_m : directed scoreboard bench for the Grostl sequencer
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_grostl_control_serial_m;

    logic       clk = 1'b0;
    logic       rst;
    logic       start_i;
    logic       first_i;
    logic       busy_o, done_o, m_load_o, wr_m_o, wr_h_o;
    logic [1:0] sel_m_o;
    logic       sel_h_o, sel_d_o, sel_pq_o;
    logic [3:0] rnd_o;
    logic [2:0] col_o;
    logic [16:0] obs;

    int n_cmp  = 0;
    int n_fail = 0;
    logic [16:0] sb_q[$];

    grostl_control_serial_m #(.ROUNDS(10)) dut (
        .clk      (clk),
        .rst      (rst),
        .start_i  (start_i),
        .first_i  (first_i),
        .busy_o   (busy_o),
        .done_o   (done_o),
        .m_load_o (m_load_o),
        .wr_m_o   (wr_m_o),
        .wr_h_o   (wr_h_o),
        .sel_m_o  (sel_m_o),
        .sel_h_o  (sel_h_o),
        .sel_d_o  (sel_d_o),
        .sel_pq_o (sel_pq_o),
        .rnd_o    (rnd_o),
        .col_o    (col_o)
    );

    always #5 clk = ~clk;

    assign obs = {busy_o, done_o, m_load_o, wr_m_o, wr_h_o, sel_m_o,
                  sel_h_o, sel_d_o, sel_pq_o, rnd_o, col_o};

    // Expected outputs in cycle t after the start edge (t=0 means idle).
    function automatic logic [16:0] exp_at(input int t, input logic f);
        logic       busy, done, mload, wrm, wrh, selh, seld, selpq;
        logic [1:0] selm;
        logic [3:0] rnd;
        logic [2:0] col;
        int         j;
        busy = 1'b0; done = 1'b0; mload = 1'b0; wrm = 1'b0; wrh = 1'b0;
        selh = 1'b0; seld = 1'b0; selpq = 1'b0; selm = 2'd0;
        rnd = 4'd0; col = 3'd0;
        if (t >= 1 && t <= 326) busy = 1'b1;
        if (t == 1) begin
            mload = 1'b1; wrm = 1'b1; wrh = f;
        end else if (t == 2) begin
            wrm = 1'b1; selm = 2'd2;
        end else if ((t >= 3 && t <= 162) || (t >= 165 && t <= 324)) begin
            j     = (t <= 162) ? t - 3 : t - 165;
            selpq = (t >= 165);
            selm  = 2'd1;
            rnd   = 4'(j / 16);
            col   = 3'((j % 16) / 2);
            seld  = ((j % 16) == 0);
            wrm   = ((j % 2) == 1);
        end else if (t == 163) begin
            wrh = 1'b1; selh = 1'b1;
        end else if (t == 164) begin
            mload = 1'b1; wrm = 1'b1;
        end else if (t == 325) begin
            wrm = 1'b1; selm = 2'd2; wrh = 1'b1; selh = 1'b1;
        end else if (t == 326) begin
            done = 1'b1;
        end
        return {busy, done, mload, wrm, wrh, selm, selh, seld, selpq, rnd, col};
    endfunction

    task automatic step(input logic [16:0] e, input int t, input string tag);
        logic [16:0] want;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        want = sb_q.pop_front();
        n_cmp++;
        assert (obs === want) else begin
            n_fail++;
            $error("FAIL %s t=%0d observed=%h expected=%h", tag, t, obs, want);
        end
    endtask

    // One full compression; hold keeps start high throughout, noise pokes
    // start and first while busy.
    task automatic run_op(input logic f, input bit hold, input bit noise);
        start_i = 1'b1;
        first_i = f;
        for (int t = 1; t <= 326; t++) begin
            step(exp_at(t, f), t, "op");
            if (!hold) start_i = (noise && t >= 40 && t <= 80) ? 1'($urandom % 2) : 1'b0;
            if (noise) first_i = 1'($urandom % 2);
        end
        start_i = hold;
        step(exp_at(0, f), 327, "idle_after_done");
    endtask

    initial begin
        rst     = 1'b1;
        start_i = 1'b0;
        first_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 20; i++) step(exp_at(0, 1'b0), 0, "reset_idle");

        run_op(1'b1, 1'b0, 1'b0);
        run_op(1'b0, 1'b0, 1'b1);

        // Reset asserted during cycle 100 of the P permutation.
        start_i = 1'b1;
        first_i = 1'b1;
        for (int t = 1; t <= 100; t++) begin
            step(exp_at(t, 1'b1), t, "pre_rst");
            start_i = 1'b0;
        end
        rst = 1'b1;
        step(exp_at(0, 1'b0), 101, "mid_rst");
        rst = 1'b0;
        for (int i = 0; i < 3; i++) step(exp_at(0, 1'b0), 0, "post_rst_idle");
        run_op(1'b1, 1'b0, 1'b0);

        // Start held high across two back-to-back compressions.
        run_op(1'b1, 1'b1, 1'b0);
        run_op(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(exp_at(0, 1'b0), 0, "final_idle");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
